// File: rtl/rv_axi_read_mem_bridge_if.sv
// ---------------------------------------------------------------------------
// rv_axi_read_mem_bridge_if
// Bundles the AXI4 read channels (AR, R) and the simple in-order memory port
// of rv_axi_read_mem_bridge.
//   slave  : bridge view (accepts AR, drives R, issues memory requests)
//   master : environment view (AXI read master plus memory)
// Signals:
//   AR : ARVALID ARREADY ARADDR ARBURST ARLEN ARSIZE ARID
//        ARCACHE ARLOCK ARPROT ARQOS ARUSER (last five carried but unused)
//   R  : RVALID RREADY RDATA RLAST RRESP RID
//   mem: mem_req_valid mem_req_ready mem_req_addr
//        mem_resp_valid mem_resp_ready mem_resp_data
// ---------------------------------------------------------------------------
interface rv_axi_read_mem_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1,
   parameter int USER_WIDTH = 1
);
   logic                  ARVALID;
   logic                  ARREADY;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [1:0]            ARBURST;
   logic [7:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic [ID_WIDTH-1:0]   ARID;
   logic [3:0]            ARCACHE;
   logic                  ARLOCK;
   logic [2:0]            ARPROT;
   logic [3:0]            ARQOS;
   logic [USER_WIDTH-1:0] ARUSER;

   logic                  RVALID;
   logic                  RREADY;
   logic [DATA_WIDTH-1:0] RDATA;
   logic                  RLAST;
   logic [1:0]            RRESP;
   logic [ID_WIDTH-1:0]   RID;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_WIDTH-1:0] mem_req_addr;
   logic                  mem_resp_valid;
   logic                  mem_resp_ready;
   logic [DATA_WIDTH-1:0] mem_resp_data;

   modport slave (
      input  ARVALID, ARADDR, ARBURST, ARLEN, ARSIZE, ARID,
             ARCACHE, ARLOCK, ARPROT, ARQOS, ARUSER,
      output ARREADY,
      output RVALID, RDATA, RLAST, RRESP, RID,
      input  RREADY,
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready,
      input  mem_resp_valid, mem_resp_data,
      output mem_resp_ready
   );

   modport master (
      output ARVALID, ARADDR, ARBURST, ARLEN, ARSIZE, ARID,
             ARCACHE, ARLOCK, ARPROT, ARQOS, ARUSER,
      input  ARREADY,
      input  RVALID, RDATA, RLAST, RRESP, RID,
      output RREADY,
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready,
      output mem_resp_valid, mem_resp_data,
      input  mem_resp_ready
   );
endinterface

// File: rtl/rv_axi_read_mem_bridge.sv
// ---------------------------------------------------------------------------
// rv_axi_read_mem_bridge
// AXI4 read-side slave. Accepts one AR burst at a time (FIXED/INCR/WRAP),
// expands it into one request per beat on an in-order valid/ready memory
// port and returns the beats on R with RID/RLAST/RRESP. A metadata FIFO of
// DEPTH entries ({id,last,err}) bounds the number of outstanding beats.
// Illegal bursts produce ARLEN+1 SLVERR beats without touching memory.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (memory side must reset with it)
//   bus  : rv_axi_read_mem_bridge_if.slave (AR, R, mem_req, mem_resp)
//
// Configuration macro:
//   RV_AXI_READ_MEM_BRIDGE_WRAP_EN : when defined WRAP bursts with
//   ARLEN in {1,3,7,15} are served; otherwise every WRAP burst is illegal.
// ---------------------------------------------------------------------------
module rv_axi_read_mem_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 1,
   parameter int USER_WIDTH = 1,
   parameter int DEPTH      = 4
) (
   input logic                     clk,
   input logic                     rst,
   rv_axi_read_mem_bridge_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH/8));
   localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(DATA_WIDTH/8 - 1);

   localparam logic [1:0] AXI_FIXED = 2'b00;
   localparam logic [1:0] AXI_INCR  = 2'b01;
   localparam logic [1:0] AXI_WRAP  = 2'b10;
   localparam logic [1:0] AXI_UNDEF = 2'b11;

`ifdef RV_AXI_READ_MEM_BRIDGE_WRAP_EN
   localparam logic WRAP_EN = 1'b1;
`else
   localparam logic WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, BURST, ERR} state_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic                last;
      logic                err;
   } meta_t;

   state_t                state, state_nxt;
   logic                  ar_en;
   logic                  arready;
   logic                  ar_hs;
   logic                  ar_bad;
   logic                  req_valid;
   logic                  push;
   logic                  push_err;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic                  beat_last;

   logic [ADDR_WIDTH-1:0] addr;
   logic [7:0]            len;
   logic [7:0]            cnt;
   logic [2:0]            size;
   logic [1:0]            burst;
   logic [ID_WIDTH-1:0]   id;

   meta_t                 fifo [DEPTH];
   meta_t                 head;
   logic [PW-1:0]         wptr, rptr;
   logic [CW-1:0]         count;

   logic                  unused_attr;
   logic [USER_WIDTH-1:0] unused_user;

   assign unused_attr = ^{bus.ARCACHE, bus.ARLOCK, bus.ARPROT, bus.ARQOS};
   assign unused_user = bus.ARUSER;

   function automatic logic burst_illegal(input logic [1:0] b,
                                          input logic [7:0] l,
                                          input logic [2:0] s);
      logic len_ok;
      logic bad;
      len_ok = (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
      bad    = (s > SIZE_MAX) || (b == AXI_UNDEF);
      if (b == AXI_WRAP)
         bad = bad || !WRAP_EN || !len_ok;
      return bad;
   endfunction

   // INCR aligns down before stepping so an unaligned first beat lands on
   // the next size boundary; WRAP keeps the upper bits of the wrap window.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0]            s,
                                                      input logic [1:0]            b,
                                                      input logic [7:0]            l);
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] bound;
      incr  = ADDR_WIDTH'(1) << s;
      bound = (ADDR_WIDTH'(l) + ADDR_WIDTH'(1)) << s;
      case (b)
         AXI_FIXED: return a;
         AXI_WRAP:  return (a & ~(bound - ADDR_WIDTH'(1))) |
                           ((a + incr) & (bound - ADDR_WIDTH'(1)));
         default:   return (a & ~(incr - ADDR_WIDTH'(1))) + incr;
      endcase
   endfunction

   // ---------------- FSM: state register ----------------
   // ar_en keeps ARREADY low for the first cycle after reset release.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ar_en <= 1'b0;
      end else begin
         state <= state_nxt;
         ar_en <= 1'b1;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ar_hs) state_nxt = ar_bad ? ERR : BURST;
         BURST:   if (push && beat_last) state_nxt = IDLE;
         ERR:     if (push && beat_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // full is the pre-pop occupancy, so a pop never frees a slot for a push
   // in the same cycle.
   always_comb begin
      arready   = 1'b0;
      req_valid = 1'b0;
      push      = 1'b0;
      push_err  = 1'b0;
      case (state)
         IDLE:  arready = ar_en;
         BURST: begin
            req_valid = !full;
            push      = !full && bus.mem_req_ready;
         end
         ERR: begin
            push     = !full;
            push_err = 1'b1;
         end
         default: ;
      endcase
   end

   assign ar_hs     = bus.ARVALID && arready;
   assign ar_bad    = burst_illegal(bus.ARBURST, bus.ARLEN, bus.ARSIZE);
   assign beat_last = (cnt == len);

   assign bus.ARREADY       = arready;
   assign bus.mem_req_valid = req_valid;
   assign bus.mem_req_addr  = addr & ~LANE_MASK;

   // Burst context: latched on AR handshake, stepped on every pushed beat.
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         addr  <= bus.ARADDR;
         len   <= bus.ARLEN;
         size  <= bus.ARSIZE;
         burst <= bus.ARBURST;
         id    <= bus.ARID;
         cnt   <= 8'd0;
      end else if (push) begin
         addr <= next_addr(addr, size, burst, len);
         cnt  <= cnt + 8'd1;
      end
   end

   // Metadata FIFO storage (data only, no reset).
   always_ff @(posedge clk) begin
      if (push)
         fifo[wptr] <= '{id: id, last: beat_last, err: push_err};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (!push && pop)
            count <= count - 1'b1;
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = fifo[rptr];

   // R path is combinational from the FIFO head; error beats need no memory
   // data and are presented immediately.
   assign bus.RVALID         = !empty && (head.err || bus.mem_resp_valid);
   assign bus.RDATA          = head.err ? '0 : bus.mem_resp_data;
   assign bus.RRESP          = head.err ? 2'b10 : 2'b00;
   assign bus.RLAST          = head.last && !empty;
   assign bus.RID            = head.id;
   assign bus.mem_resp_ready = bus.RREADY && !empty && !head.err;
   assign pop                = bus.RVALID && bus.RREADY;

endmodule
